// File: rtl/spi_master_ctrl.sv
// Single-clock SPI master: 1..MAX_BYTES byte transactions over a start/busy/done handshake.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift bits LSB-first within each byte.
//
// state | meaning
// IDLE  | waiting for a legal start; CS high, SCLK at CPOL, MOSI high
// SETUP | one tick with CS asserted before the first SCLK edge
// SHIFT | 16*N ticks, SCLK toggles each tick
// HOLD  | one tick with SCLK at CPOL before CS releases
module spi_master_ctrl #(
  parameter int  CLK_DIV   = 5,
  parameter int  MAX_BYTES = 4,
  parameter int  CPOL      = 1,
  parameter int  CPHA      = 1,
  parameter int  NUM_CS    = 1,
  localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int BW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CSW-1:0]         cs_sel_i,
  input  logic [BW-1:0]          tx_bytes_i,
  input  logic [8*MAX_BYTES-1:0] tx_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [8*MAX_BYTES-1:0] rx_data_o,
  output logic [BW-1:0]          rx_bytes_valid_o,
  output logic                   spi_sclk_o,
  output logic                   spi_mosi_o,
  input  logic                   spi_miso_i,
  output logic [NUM_CS-1:0]      spi_cs_n_o
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int EW = $clog2(16 * MAX_BYTES + 1);
  localparam int IW = $clog2(8 * MAX_BYTES);
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q;
  logic [8*MAX_BYTES-1:0] tx_q;
  logic [BW-1:0]          n_q;
  logic [CSW-1:0]         cs_q;
  logic [8*MAX_BYTES-1:0] rx_q;
  logic [BW-1:0]          rxv_q;
  logic [6:0]             rx_sh;
  logic [2:0]             bit_q;
  logic [BW-1:0]          byte_q;
  logic [EW-1:0]          edge_q;
  logic                   sclk_q, mosi_q, done_q;

  logic       tick, accept, lead, last_edge, shift_tick, sample_ev, drive_ev;
  logic       tx_bit, first_bit;
  logic [2:0] bit_pos;
  logic [7:0] rx_nxt;

  assign tick   = (state_q != IDLE) && (div_q == DW'(CLK_DIV - 1));
  // A start landing in the done cycle is dropped so CS stays high at least two cycles.
  assign accept = (state_q == IDLE) && !done_q && start_i && (tx_bytes_i != '0) &&
                  (32'(tx_bytes_i) <= MAX_BYTES) && (32'(cs_sel_i) < NUM_CS);

  assign lead       = (sclk_q == SCLK_IDLE);
  assign last_edge  = (edge_q == ((EW'(n_q) << 4) - EW'(1)));
  assign shift_tick = (state_q == SHIFT) && tick;
  assign sample_ev  = shift_tick && ((CPHA != 0) ? !lead : lead);
  assign drive_ev   = shift_tick && ((CPHA != 0) ? lead : !lead);

  assign bit_pos   = LSB_FIRST ? bit_q : (3'd7 - bit_q);
  assign tx_bit    = tx_q[IW'({byte_q, bit_pos})];
  assign first_bit = LSB_FIRST ? tx_data_i[0] : tx_data_i[7];
  assign rx_nxt    = LSB_FIRST ? {spi_miso_i, rx_sh} : {rx_sh, spi_miso_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)            state_d = SETUP;
      SETUP:   if (tick)              state_d = SHIFT;
      SHIFT:   if (tick && last_edge) state_d = HOLD;
      HOLD:    if (tick)              state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    spi_cs_n_o = '1;
    if (state_q != IDLE) spi_cs_n_o = ~(NUM_CS'(1) << cs_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == IDLE) div_q <= '0;
    else if (tick)                div_q <= '0;
    else                          div_q <= div_q + DW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q   <= '0;
      n_q    <= '0;
      cs_q   <= '0;
      rx_q   <= '0;
      rxv_q  <= '0;
      rx_sh  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      edge_q <= '0;
      sclk_q <= SCLK_IDLE;
      mosi_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == HOLD) && tick;
      if (accept) begin
        tx_q   <= tx_data_i;
        n_q    <= tx_bytes_i;
        cs_q   <= cs_sel_i;
        rx_q   <= '0;
        rxv_q  <= '0;
        bit_q  <= '0;
        byte_q <= '0;
        edge_q <= '0;
        sclk_q <= SCLK_IDLE;
        mosi_q <= (CPHA != 0) ? 1'b1 : first_bit;
      end
      if (shift_tick) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + EW'(1);
        if (last_edge)     mosi_q <= 1'b1;
        else if (drive_ev) mosi_q <= tx_bit;
      end
      if (sample_ev) begin
        rx_sh <= LSB_FIRST ? rx_nxt[7:1] : rx_nxt[6:0];
        bit_q <= bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          for (int k = 0; k < MAX_BYTES; k++)
            if (byte_q == BW'(k)) rx_q[8*k +: 8] <= rx_nxt;
          rxv_q <= byte_q + BW'(1);
          if (byte_q != n_q - BW'(1)) byte_q <= byte_q + BW'(1);
        end
      end
    end
  end

  assign done_o           = done_q;
  assign rx_data_o        = rx_q;
  assign rx_bytes_valid_o = rxv_q;
  assign spi_sclk_o       = sclk_q;
  assign spi_mosi_o       = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: dut_a is mode 3 with MOSI looped to MISO and three chip
// selects, dut_b is mode 0 talking to a small slave model that returns a fixed word.
module tb_spi_master_ctrl;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start_a, busy_a, done_a, sclk_a, mosi_a;
  logic [1:0]  cs_sel_a;
  logic [2:0]  nb_a, rxv_a, cs_a;
  logic [31:0] txd_a, rx_a;

  logic        start_b, busy_b, done_b, sclk_b, mosi_b, miso_b;
  logic [0:0]  cs_sel_b, cs_b;
  logic [2:0]  nb_b, rxv_b;
  logic [31:0] txd_b, rx_b;

  spi_master_ctrl #(.CLK_DIV(2), .MAX_BYTES(4), .CPOL(1), .CPHA(1), .NUM_CS(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .cs_sel_i(cs_sel_a), .tx_bytes_i(nb_a),
    .tx_data_i(txd_a), .busy_o(busy_a), .done_o(done_a), .rx_data_o(rx_a),
    .rx_bytes_valid_o(rxv_a), .spi_sclk_o(sclk_a), .spi_mosi_o(mosi_a), .spi_miso_i(mosi_a),
    .spi_cs_n_o(cs_a));

  spi_master_ctrl #(.CLK_DIV(2), .MAX_BYTES(4), .CPOL(0), .CPHA(0), .NUM_CS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .cs_sel_i(cs_sel_b), .tx_bytes_i(nb_b),
    .tx_data_i(txd_b), .busy_o(busy_b), .done_o(done_b), .rx_data_o(rx_b),
    .rx_bytes_valid_o(rxv_b), .spi_sclk_o(sclk_b), .spi_mosi_o(mosi_b), .spi_miso_i(miso_b),
    .spi_cs_n_o(cs_b));

  logic        sel;
  wire         obs_done = sel ? done_b : done_a;
  wire         obs_sclk = sel ? sclk_b : sclk_a;
  wire         obs_mosi = sel ? mosi_b : mosi_a;
  wire         obs_cpol = sel ? 1'b0 : 1'b1;
  wire [2:0]   obs_rxv  = sel ? rxv_b : rxv_a;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wire-order bit stream: first bit on the wire ends up most significant.
  function automatic logic [63:0] exp_ser(input logic [31:0] d, input int n);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int k = 0; k < n; k++) begin
      b = d[8*k +: 8];
      for (int i = 0; i < 8; i++) r = {r[62:0], LSB ? b[i] : b[7-i]};
    end
    return r;
  endfunction

  logic [31:0] slv_ser;
  int          sidx;
  initial begin
    logic [63:0] t;
    t       = exp_ser(32'hCAFEBABE, 4);
    slv_ser = t[31:0];
    miso_b  = 1'b1;
    forever begin
      @(negedge cs_b[0]);
      sidx   = 0;
      miso_b = slv_ser[31];
      forever begin
        @(negedge sclk_b or posedge cs_b[0]);
        if (cs_b[0]) break;
        sidx++;
        miso_b = (sidx < 32) ? slv_ser[31 - sidx] : 1'b1;
      end
      miso_b = 1'b1;
    end
  end

  task automatic kick(input logic which, input int cs, input int n, input logic [31:0] d,
                      input logic hold);
    @(negedge clk);
    sel = which;
    if (which) begin
      cs_sel_b = 1'(cs); nb_b = 3'(n); txd_b = d; start_b = 1'b1;
    end else begin
      cs_sel_a = 2'(cs); nb_a = 3'(n); txd_a = d; start_a = 1'b1;
    end
    @(negedge clk);
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  // Called in cycle T+1; returns the cycle index (relative to T) in which done was seen.
  task automatic wait_done(input int limit, output int cyc, output int tog,
                           output logic [63:0] cap, output logic [15:0] hist);
    logic       ps;
    logic [2:0] pv;
    cyc = 1; tog = 0; cap = '0; hist = '0;
    ps = obs_sclk; pv = obs_rxv;
    while (!obs_done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (obs_sclk !== ps) begin
        tog++;
        ps = obs_sclk;
        if (obs_sclk != obs_cpol) cap = {cap[62:0], obs_mosi};
      end
      if (obs_rxv !== pv) begin
        pv   = obs_rxv;
        hist = {hist[11:0], 1'b0, obs_rxv};
      end
    end
  endtask

  task automatic quiet_a(input int cycles, output logic act);
    act = 1'b0;
    repeat (cycles) begin
      if (busy_a || done_a || cs_a !== 3'b111) act = 1'b1;
      @(negedge clk);
    end
  endtask

  int          cyc, tog;
  logic [63:0] cap;
  logic [15:0] hist;
  logic        act;
  int          ill_cs[3] = '{0, 0, 3};
  int          ill_n[3]  = '{0, 5, 1};

  initial begin
    rst = 1'b1; sel = 1'b0;
    start_a = 0; cs_sel_a = 0; nb_a = 0; txd_a = 0;
    start_b = 0; cs_sel_b = 0; nb_b = 0; txd_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_a", cs_a, 3'b111);
    chk("rst_sclk_a", sclk_a, 1'b1);
    chk("rst_sclk_b", sclk_b, 1'b0);
    chk("rst_mosi_a", mosi_a, 1'b1);
    chk("rst_busy_done_a", {busy_a, done_a}, 2'b00);
    chk("rst_rx_a", {rx_a, rxv_a}, '0);
    chk("rst_cs_b", cs_b, 1'b1);

    // mode 3, one byte, loopback
    kick(0, 0, 1, 32'h0000_00A5, 0);
    chk("m3_busy", busy_a, 1'b1);
    chk("m3_cs", cs_a, 3'b110);
    wait_done(200, cyc, tog, cap, hist);
    chk("m3_done", done_a, 1'b1);
    chk("m3_cycle", cyc, 37);
    chk("m3_busy_at_done", busy_a, 1'b0);
    chk("m3_cs_at_done", cs_a, 3'b111);
    chk("m3_toggles", tog, 16);
    chk("m3_mosi_seq", cap[7:0], exp_ser(32'hA5, 1));
    chk("m3_rx", rx_a, 32'h0000_00A5);
    chk("m3_rxv", rxv_a, 3'd1);
    chk("m3_rxv_steps", hist, 16'h0001);

    // mode 0, four bytes against the slave model
    kick(1, 0, 4, 32'h1234_5678, 0);
    chk("m0_busy", busy_b, 1'b1);
    chk("m0_cs", cs_b, 1'b0);
    wait_done(400, cyc, tog, cap, hist);
    chk("m0_done", done_b, 1'b1);
    chk("m0_cycle", cyc, 133);
    chk("m0_busy_at_done", {busy_b, cs_b}, 2'b01);
    chk("m0_toggles", tog, 64);
    chk("m0_mosi_seq", cap[31:0], exp_ser(32'h1234_5678, 4));
    chk("m0_rx", rx_b, 32'hCAFE_BABE);
    chk("m0_rxv", rxv_b, 3'd4);
    chk("m0_rxv_steps", hist, 16'h1234);

    // illegal requests: zero bytes, too many bytes, chip select out of range
    for (int i = 0; i < 3; i++) begin
      kick(0, ill_cs[i], ill_n[i], 32'hFFFF_FFFF, 0);
      quiet_a(20, act);
      chk($sformatf("illegal%0d_activity", i), act, 1'b0);
    end

    // reset during byte 2, then a clean transfer
    kick(0, 1, 4, 32'h1122_3344, 0);
    repeat (78) @(negedge clk);
    chk("mid_rxv", rxv_a, 3'd2);
    chk("mid_cs", cs_a, 3'b101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cs_busy", {cs_a, busy_a}, 4'b1110);
    chk("mid_rst_rx", {rx_a, rxv_a}, '0);
    chk("mid_rst_sclk_mosi", {sclk_a, mosi_a, done_a}, 3'b110);
    quiet_a(40, act);
    chk("mid_rst_no_done", act, 1'b0);
    kick(0, 1, 2, 32'h0000_BEEF, 0);
    wait_done(200, cyc, tog, cap, hist);
    chk("post_rst_cycle", cyc, 69);
    chk("post_rst_rx", rx_a, 32'h0000_BEEF);
    chk("post_rst_rxv", rxv_a, 3'd2);
    chk("post_rst_mosi_seq", cap[15:0], exp_ser(32'h0000_BEEF, 2));

    // start held through done: not taken in done cycle, taken the cycle after
    kick(0, 2, 1, 32'h0000_003C, 1);
    chk("b2b_cs", cs_a, 3'b011);
    wait_done(200, cyc, tog, cap, hist);
    chk("b2b_done", {done_a, busy_a}, 2'b10);
    @(negedge clk);
    chk("b2b_gap_busy_cs", {busy_a, cs_a}, 4'b0111);
    @(negedge clk);
    chk("b2b_reaccept", busy_a, 1'b1);
    start_a = 1'b0;
    wait_done(200, cyc, tog, cap, hist);
    chk("b2b_second_cycle", cyc, 37);
    chk("b2b_second_rx", rx_a, 32'h0000_003C);

    // bit order within a byte
    kick(0, 0, 1, 32'h0000_0001, 0);
    wait_done(200, cyc, tog, cap, hist);
    chk("order_first_bit", cap[7], LSB ? 1'b1 : 1'b0);
    chk("order_mosi_seq", cap[7:0], exp_ser(32'h01, 1));
    chk("order_rx", rx_a, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
